// File: rtl/psum_pkg.sv
// Shared sizing constants and FSM encoding for the partial-sum drain block.
package psum_pkg;

    localparam int PSUM_COL   = 8;
    localparam int PSUM_BW_IN = 16;
    localparam int PSUM_ACC_W = 20;
    localparam int PSUM_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/psum_lane_acc.sv
// One psum lane: sign-extending accumulator with clear, plus saturate-then-ReLU output.
module psum_lane_acc
    import psum_pkg::*;
#(
    parameter int BW_IN = PSUM_BW_IN,
    parameter int ACC_W = PSUM_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [BW_IN-1:0] din_i,
    output logic [BW_IN-1:0] dout_o
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-BW_IN+1){1'b0}}, {(BW_IN-1){1'b1}}};

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] din_ext;

    assign din_ext = {{(ACC_W-BW_IN){din_i[BW_IN-1]}}, din_i};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + din_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Negative sums collapse to zero, so the lower saturation bound never matters.
    always_comb begin
        dout_o = acc_q[BW_IN-1:0];
        if (acc_q > SAT_MAX) begin
            dout_o = SAT_MAX[BW_IN-1:0];
        end else if (acc_q[ACC_W-1]) begin
            dout_o = '0;
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Pops len words from a registered-read FIFO, sums them lane-wise, and presents
// the saturated/ReLU result with a valid/ready handshake (transfer when both high).
module psum_drain
    import psum_pkg::*;
#(
    parameter int COL   = PSUM_COL,
    parameter int BW_IN = PSUM_BW_IN,
    parameter int ACC_W = PSUM_ACC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           len,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [BW_IN*COL-1:0] fifo_rd_data,
    output logic [BW_IN*COL-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output state_e               dbg_state_o
);

    state_e     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [3:0] issued_q, issued_d;
    logic [3:0] recv_q, recv_d;
    logic       pend_q, pend_d;
    logic       zdone_q, zdone_d;
    logic       acc_clr;

    logic [BW_IN*COL-1:0] lanes;

    for (genvar i = 0; i < COL; i++) begin : g_lane
        psum_lane_acc #(
            .BW_IN(BW_IN),
            .ACC_W(ACC_W)
        ) u_acc (
            .clk   (clk),
            .reset (reset),
            .clr_i (acc_clr),
            .add_i (pend_q),
            .din_i (fifo_rd_data[i*BW_IN +: BW_IN]),
            .dout_o(lanes[i*BW_IN +: BW_IN])
        );
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        recv_d     = recv_q;
        zdone_d    = 1'b0;
        acc_clr    = 1'b0;
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        done       = zdone_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != 4'd0) begin
                        len_d    = len;
                        issued_d = '0;
                        recv_d   = '0;
                        acc_clr  = 1'b1;
                        state_d  = FILL;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            FILL: begin
                fifo_rd_en = (issued_q < len_q) && !fifo_empty;
                if (fifo_rd_en) begin
                    issued_d = issued_q + 4'd1;
                end
                // Data for the pop issued last cycle arrives now.
                if (pend_q) begin
                    recv_d = recv_q + 4'd1;
                    if (recv_q + 4'd1 == len_q) begin
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d = fifo_rd_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            pend_q   <= 1'b0;
            zdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            pend_q   <= pend_d;
            zdone_q  <= zdone_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign out_data    = out_valid ? lanes : '0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with a registered-read FIFO model and hand-computed results.
module tb_psum_drain;
    import psum_pkg::*;

    localparam int W = PSUM_BW_IN * PSUM_COL;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   len;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_rd_data = '0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
    state_e       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: pushes from the stimulus thread, pops on rd_en at the clock edge.
    logic [W-1:0] fmem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
            pop_cnt      <= pop_cnt + 1;
        end
    end

    psum_drain dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] splat(input logic [15:0] v);
        return {PSUM_COL{v}};
    endfunction

    task automatic push(input logic [W-1:0] w);
        fmem[wr_ptr[7:0]] = w;
        wr_ptr++;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic start_job(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycles counted from the negedge where start was raised; bounded.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int pops0;
        int hits;
        logic [4:0]   pat;
        logic [W-1:0] w;
        logic [W-1:0] exp_w;

        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_state", W'(dbg_state), W'(IDLE));
        check("rst_busy", W'(busy), '0);
        check("rst_valid", W'(out_valid), '0);
        check("rst_done", W'(done), '0);
        check("rst_rd_en", W'(fifo_rd_en), '0);
        check("rst_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);

        // Single pop
        push(splat(16'h0005));
        pops0 = pop_cnt;
        start_job(4'd1);
        check("single_rd_en", W'(fifo_rd_en), W'(1));
        check("single_busy", W'(busy), W'(1));
        wait_valid(cyc);
        check("single_latency", W'(cyc), W'(3));
        check("single_valid", W'(out_valid), W'(1));
        check("single_data", out_data, splat(16'h0005));
        check("single_done", W'(done), W'(1));
        check("single_pops", W'(pop_cnt - pops0), W'(1));
        @(negedge clk);
        check("single_idle", W'(busy), '0);
        check("single_done_off", W'(done), '0);

        // Back-to-back pops with one surplus word left in the FIFO
        for (int i = 0; i < 5; i++) push(splat(16'h0100));
        pops0 = pop_cnt;
        start_job(4'd4);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            pat[i] = fifo_rd_en;
            @(negedge clk);
        end
        check("b2b_pattern", W'(pat), W'(5'b01111));
        wait_valid(cyc);
        check("b2b_valid", W'(out_valid), W'(1));
        check("b2b_data", out_data, splat(16'h0400));
        check("b2b_pops", W'(pop_cnt - pops0), W'(4));
        @(negedge clk);
        check("b2b_no_extra_pop", W'(pop_cnt - pops0), W'(4));
        flush();

        // Saturation and ReLU
        w = '0;
        w[0*16 +: 16] = 16'h7000;
        w[1*16 +: 16] = 16'h8000;
        w[2*16 +: 16] = 16'h0001;
        w[3*16 +: 16] = 16'hFFFF;
        w[4*16 +: 16] = 16'h1234;
        exp_w = '0;
        exp_w[0*16 +: 16] = 16'h7FFF;
        exp_w[1*16 +: 16] = 16'h0000;
        exp_w[2*16 +: 16] = 16'h0003;
        exp_w[3*16 +: 16] = 16'h0000;
        exp_w[4*16 +: 16] = 16'h369C;
        for (int i = 0; i < 3; i++) push(w);
        start_job(4'd3);
        wait_valid(cyc);
        check("sat_valid", W'(out_valid), W'(1));
        check("sat_data", out_data, exp_w);
        @(negedge clk);

        // Empty-FIFO stall then consumer backpressure
        out_ready = 1'b0;
        push(splat(16'h0010));
        pops0 = pop_cnt;
        start_job(4'd2);
        check("stall_first_pop", W'(fifo_rd_en), W'(1));
        @(negedge clk);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            if (fifo_rd_en) hits++;
            if (!busy) hits += 100;
            @(negedge clk);
        end
        check("stall_no_pop", W'(hits), '0);
        push(splat(16'h0020));
        wait_valid(cyc);
        check("stall_valid", W'(out_valid), W'(1));
        check("stall_data", out_data, splat(16'h0030));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_hold_data", out_data, splat(16'h0030));
            check("bp_no_done", W'(done), '0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_done", W'(done), W'(1));
        check("stall_pops", W'(pop_cnt - pops0), W'(2));
        @(negedge clk);
        check("bp_idle", W'(busy), '0);
        check("bp_valid_off", W'(out_valid), '0);

        // len = 0: done next cycle, no pop even with data available
        push(splat(16'h0077));
        pops0 = pop_cnt;
        start_job(4'd0);
        check("len0_done", W'(done), W'(1));
        check("len0_busy", W'(busy), '0);
        check("len0_rd_en", W'(fifo_rd_en), '0);
        @(negedge clk);
        check("len0_done_off", W'(done), '0);
        check("len0_pops", W'(pop_cnt - pops0), '0);
        flush();

        // Mid-job reset during FILL
        push(splat(16'h0011));
        push(splat(16'h0022));
        start_job(4'd3);
        repeat (3) @(negedge clk);
        check("mid_busy", W'(busy), W'(1));
        check("mid_state", W'(dbg_state), W'(FILL));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", W'(dbg_state), W'(IDLE));
        check("mid_rst_busy", W'(busy), '0);
        check("mid_rst_rd_en", W'(fifo_rd_en), '0);
        check("mid_rst_valid", W'(out_valid), '0);
        check("mid_rst_done", W'(done), '0);
        check("mid_rst_data", out_data, '0);
        reset = 1'b0;
        @(negedge clk);
        push(splat(16'h0007));
        start_job(4'd1);
        wait_valid(cyc);
        check("post_rst_data", out_data, splat(16'h0007));
        @(negedge clk);

        // start during OUT is ignored; a new job starts right after returning to IDLE
        out_ready = 1'b0;
        push(splat(16'h0002));
        pops0 = pop_cnt;
        start_job(4'd1);
        push(splat(16'h0009));
        push(splat(16'h0009));
        wait_valid(cyc);
        check("out_ign_valid", W'(out_valid), W'(1));
        start = 1'b1;
        len   = 4'd2;
        hits  = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (fifo_rd_en) hits++;
            if (!out_valid) hits += 100;
        end
        start = 1'b0;
        check("out_ign_no_pop", W'(hits), '0);
        check("out_ign_pops", W'(pop_cnt - pops0), W'(1));
        check("out_ign_data", out_data, splat(16'h0002));
        out_ready = 1'b1;
        #1;
        check("out_ign_done", W'(done), W'(1));
        @(negedge clk);
        check("restart_idle", W'(dbg_state), W'(IDLE));
        start_job(4'd2);
        check("restart_busy", W'(busy), W'(1));
        wait_valid(cyc);
        check("restart_valid", W'(out_valid), W'(1));
        check("restart_data", out_data, splat(16'h0012));
        check("restart_pops", W'(pop_cnt - pops0), W'(3));
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter COL, default 8, number of psum lanes per word.
REQ-002 SHALL have parameter BW_IN, default 16, lane width in bits (bw_psum+4 with bw=4).
REQ-003 SHALL have parameter ACC_W, default 20, internal lane accumulator width.
REQ-004 SHALL have port clk, input, 1, single clock; the block runs in the FIFO read-clock domain.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port start, input, 1, begins one drain job when sampled high in IDLE.
REQ-007 SHALL have port len, input, 4, number of FIFO words to accumulate, sampled with start.
REQ-008 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-009 SHALL have port fifo_rd_en, output, 1, FIFO pop request.
REQ-010 SHALL have port fifo_rd_data, input, BW_IN*COL, FIFO registered read data.
REQ-011 SHALL have port out_data, output, BW_IN*COL, result lanes; lane i is at bits [i*BW_IN +: BW_IN].
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at job completion.

Function
REQ-016 SHALL implement the FSM states IDLE, FILL and OUT.
REQ-017 SHALL, in IDLE with start=1 and len!=0, latch len, clear all lane accumulators and the issued/received counters, and move to FILL.
REQ-018 SHALL, in IDLE with start=1 and len=0, pulse done on the next cycle, assert no fifo_rd_en, and stay in IDLE.
REQ-019 SHALL ignore start in FILL and OUT.
REQ-020 SHALL drive fifo_rd_en = (state==FILL) & (issued<len) & !fifo_empty, combinationally; issued increments on each asserted cycle.
REQ-021 SHALL treat fifo_rd_data as valid exactly one cycle after an asserted fifo_rd_en, tracked by a registered pend flag, so that back-to-back pops sustain 1 word/cycle.
REQ-022 SHALL, on each pend cycle, sign-extend each BW_IN lane to ACC_W and add it to that lane's accumulator, then increment received.
REQ-023 SHALL move from FILL to OUT on the cycle the accumulation of received==len completes.
REQ-024 SHALL form out_data per lane as: saturate the accumulator to signed BW_IN range [-32768, 32767], then apply ReLU (negative values become 0).
REQ-025 SHALL, in OUT, hold out_valid=1 with out_data stable until out_ready=1.
REQ-026 SHALL, on the cycle out_valid&out_ready, return to IDLE; done pulses in that same cycle.
REQ-027 SHALL stall without losing count while fifo_empty=1 mid-job, and SHALL never issue more than len pops.
REQ-028 SHALL accept a new start on the cycle immediately after returning to IDLE.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, including mid-job, force state=IDLE, clear the accumulators, counters and pend, and drive out_valid=0, done=0, busy=0, fifo_rd_en=0, out_data=0.
REQ-030 SHALL, after a mid-job reset, leave any popped-but-unaccumulated word discarded; the FIFO is reset by the same reset.

Structure
REQ-031 SHALL take COL, BW_IN, ACC_W and the FSM state encoding from a shared package psum_pkg.
REQ-032 SHALL instantiate sub-module psum_lane_acc COL times; each instance provides sign-extend, accumulate, clear, and saturate+ReLU output.

Verification
REQ-033 SHALL verify a single pop: len=1 with FIFO word all lanes 0x0005 -> one fifo_rd_en pulse, and out_data lanes = 0x0005, out_valid=1 three cycles after start.
REQ-034 SHALL verify back-to-back pops: len=4 with FIFO full of lane value 0x0100 -> 4 consecutive fifo_rd_en pulses, lanes = 0x0400.
REQ-035 SHALL verify saturation and ReLU: len=3 with lane0 0x7000 and lane1 0x8000 -> lane0=0x7FFF, lane1=0x0000.
REQ-036 SHALL verify empty stall and backpressure: len=2 with FIFO empty for 5 cycles between words -> exactly 2 pops; with out_ready=0 for 4 cycles, out_data stays stable and done pulses on the handshake.
REQ-037 SHALL verify len=0 and mid-job reset: start with len=0 -> done pulses with no pop; reset during FILL -> IDLE next cycle with all outputs 0.
REQ-038 SHALL verify that start asserted during OUT is ignored: no new pops occur until IDLE.
